// File: rtl/softmax_pkg.sv
// Shared Q6.10 definitions for the softmax stage and its neighbours.
package softmax_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;

  typedef logic signed [DATA_W-1:0] q610_t;

  localparam q610_t ONE_Q610 = 16'h0400;

  // Index width for an n-lane vector; never narrower than one bit.
  function automatic int iw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_out_serializer.sv
// Two-slot ping-pong buffer that streams a softmax vector one lane per cycle.
// Optional macro SOFTMAX_SER_TLAST_EN adds the out_last end-of-vector marker.
module softmax_out_serializer
  import softmax_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = DATA_W,
  localparam int IW = iw_of(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            valid_in,
  input  logic [N*DW-1:0] in_flat,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
`ifdef SOFTMAX_SER_TLAST_EN
  output logic            out_last,
`endif
  output logic            overflow
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [N-1:0][DW-1:0] slot [2];
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic                 wr_sel;
  logic                 rd_sel;
  logic [IW-1:0]        idx;
  logic                 capture;
  logic                 drop;
  logic                 pop;
  logic                 last_pop;

  // Capture/drop decisions use the occupancy before the edge, so a final pop
  // on the same edge never frees room for an arriving vector.
  always_comb begin
    capture    = valid_in && en && (count != 2'd2);
    drop       = valid_in && en && (count == 2'd2);
    pop        = out_valid && out_ready;
    last_pop   = pop && (idx == LAST_IDX);
    count_next = count;
    if (capture && !last_pop) begin
      count_next = count + 2'd1;
    end else if (!capture && last_pop) begin
      count_next = count - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        slot[s] <= '0;
      end
      count    <= 2'd0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      idx      <= '0;
      in_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        slot[wr_sel] <= in_flat;
        wr_sel       <= ~wr_sel;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (last_pop) begin
        idx    <= '0;
        rd_sel <= ~rd_sel;
      end else if (pop) begin
        idx <= idx + 1'b1;
      end
      count    <= count_next;
      in_ready <= (count_next < 2'd2);
    end
  end

  // Output mux reads only registered slot/index state.
  assign out_valid = (count != 2'd0);
  assign out_data  = slot[rd_sel][idx];
  assign out_idx   = idx;

`ifdef SOFTMAX_SER_TLAST_EN
  assign out_last = out_valid && (idx == LAST_IDX);
`endif

endmodule

// File: tb/tb_softmax_out_serializer.sv
// Directed scoreboard bench for softmax_out_serializer (N=8, DW=16).
module tb_softmax_out_serializer;
  import softmax_pkg::*;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int IW = 3;

  typedef logic [N*DW-1:0] vec_t;
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } elem_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            valid_in;
  vec_t            in_flat;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            overflow;
`ifdef SOFTMAX_SER_TLAST_EN
  logic            out_last;
`endif

  int    checks   = 0;
  int    failures = 0;
  elem_t sb[$];
  int    hs_count = 0;
  int    cyc      = 0;
  int    first_hs = -1;
  int    last_hs  = -1;
  logic            hold_pending = 1'b0;
  logic [DW-1:0]   held_data;
  logic [IW-1:0]   held_idx;

  softmax_out_serializer #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .valid_in (valid_in),
    .in_flat  (in_flat),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
`ifdef SOFTMAX_SER_TLAST_EN
    .out_last (out_last),
`endif
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t make_vec(input logic [DW-1:0] base, input logic [DW-1:0] step);
    vec_t v;
    for (int i = 0; i < N; i++) begin
      v[i*DW +: DW] = base + step * DW'(i);
    end
    return v;
  endfunction

  // Drives one vector for a single edge; accepted vectors go to the scoreboard.
  task automatic apply_stimulus(input vec_t v, input bit accept);
    in_flat  = v;
    valid_in = 1'b1;
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        sb.push_back('{idx: IW'(i), data: v[i*DW +: DW]});
      end
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (out_valid === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check_output({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    check_output({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  task automatic start_test();
    hs_count = 0;
    first_hs = -1;
    last_hs  = -1;
  endtask

  // Handshake monitor: pops the scoreboard, checks hold-under-backpressure.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && out_valid) begin
        check_output("hold_data", out_data, held_data);
        check_output("hold_idx", out_idx, held_idx);
      end
`ifdef SOFTMAX_SER_TLAST_EN
      check_output("out_last", out_last, out_valid && (out_idx == IW'(N-1)));
`endif
      if (out_valid && out_ready) begin
        elem_t e;
        hs_count++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (sb.size() == 0) begin
          check_output("unexpected_element", {29'd0, out_idx}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check_output("elem_data", out_data, e.data);
          check_output("elem_idx", out_idx, e.idx);
        end
      end
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
      held_idx     = out_idx;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t va, vb, vc;
    rst       = 1'b1;
    en        = 1'b1;
    valid_in  = 1'b0;
    in_flat   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_idx", out_idx, 0);
    check_output("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single vector");
    start_test();
    apply_stimulus(make_vec(16'h0080, 16'h0080), 1'b1);
    check_output("single_valid_next", out_valid, 1);
    check_output("single_idx0", out_idx, 0);
    check_output("single_lane0", out_data, 16'h0080);
    drain("single");
    check_output("single_hs", hs_count, 8);
    check_output("single_in_ready", in_ready, 1);
    check_output("single_last_lane_one", 32'(ONE_Q610), 32'(make_vec(16'h0080, 16'h0080) >> (7*DW)));

    $display("[TB] backpressure");
    start_test();
    apply_stimulus(make_vec(16'($urandom_range(0, 16'hFFFF)), 16'h1357), 1'b1);
    for (int c = 0; c < 40 && out_valid === 1'b1; c++) begin
      out_ready = (c % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    drain("bp");
    check_output("bp_hs", hs_count, 8);

    $display("[TB] ping-pong");
    start_test();
    apply_stimulus({N{16'h0200}}, 1'b1);
    tick();
    tick();
    apply_stimulus({N{16'h0100}}, 1'b1);
    check_output("pp_in_ready_full", in_ready, 0);
    drain("pp");
    check_output("pp_hs", hs_count, 16);
    check_output("pp_no_gap", last_hs - first_hs + 1, 16);
    check_output("pp_in_ready_after", in_ready, 1);

    $display("[TB] capture with final pop at count=1");
    start_test();
    apply_stimulus(make_vec(16'h0010, 16'h0011), 1'b1);
    repeat (7) tick();
    check_output("c1_idx7", out_idx, 7);
    apply_stimulus(make_vec(16'hF000, 16'h0101), 1'b1);
    check_output("c1_valid", out_valid, 1);
    check_output("c1_idx0", out_idx, 0);
    check_output("c1_in_ready", in_ready, 1);
    check_output("c1_overflow", overflow, 0);
    drain("c1");
    check_output("c1_hs", hs_count, 16);

    $display("[TB] overflow");
    start_test();
    out_ready = 1'b0;
    va = make_vec(16'h0A00, 16'h0001);
    vb = make_vec(16'h0B00, 16'h0002);
    vc = make_vec(16'h0C00, 16'h0003);
    apply_stimulus(va, 1'b1);
    check_output("ovf_in_ready_1", in_ready, 1);
    apply_stimulus(vb, 1'b1);
    check_output("ovf_in_ready_2", in_ready, 0);
    check_output("ovf_before", overflow, 0);
    apply_stimulus(vc, 1'b0);
    check_output("ovf_set", overflow, 1);
    tick();
    out_ready = 1'b1;
    drain("ovf");
    check_output("ovf_hs", hs_count, 16);
    check_output("ovf_sticky", overflow, 1);

    $display("[TB] reset mid-drain");
    start_test();
    apply_stimulus(make_vec(16'h0300, 16'h0020), 1'b1);
    repeat (3) tick();
    check_output("rmd_idx3", out_idx, 3);
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    check_output("rmd_out_valid", out_valid, 0);
    check_output("rmd_out_idx", out_idx, 0);
    check_output("rmd_out_data", out_data, 0);
    check_output("rmd_in_ready", in_ready, 1);
    check_output("rmd_overflow", overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    start_test();
    apply_stimulus(make_vec(16'h8001, 16'h0F0F), 1'b1);
    check_output("rmd_restart_idx", out_idx, 0);
    drain("rmd");
    check_output("rmd_hs", hs_count, 8);

    $display("[TB] drop with final pop at count=2");
    start_test();
    out_ready = 1'b0;
    apply_stimulus(make_vec(16'h0040, 16'h0004), 1'b1);
    apply_stimulus(make_vec(16'h0050, 16'h0005), 1'b1);
    out_ready = 1'b1;
    repeat (7) tick();
    check_output("c2_idx7", out_idx, 7);
    apply_stimulus(make_vec(16'h7777, 16'h0001), 1'b0);
    check_output("c2_overflow", overflow, 1);
    check_output("c2_in_ready", in_ready, 1);
    check_output("c2_idx0", out_idx, 0);
    drain("c2");
    check_output("c2_hs", hs_count, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
